// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU control decode: aluop selects add/sub directly or defers to funct.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  // Unknown funct codes fall back to add so the writeback stays harmless.
  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_SUB:   o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_SUB:  o_alucontrol = ALU_SUB;
          FN_AND:  o_alucontrol = ALU_AND;
          FN_OR:   o_alucontrol = ALU_OR;
          FN_SLT:  o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default:     o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: state register, next-state, Moore output
// decode and the PC-enable gate.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_cur;
  logic       w_pcwrite, w_branch, w_memwrite, w_irwrite, w_regwrite;
  logic [1:0] w_aluop;

  // While reset is high the outputs decode as FETCH even before the first edge.
  assign w_cur = reset ? 4'(S_FETCH) : r_state;
  assign state = w_cur;

  // State register; synchronous reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= 4'(S_FETCH);
    else       r_state <= w_next;
  end

  // Next-state; illegal encodings drop back to FETCH.
  always_comb begin
    w_next = 4'(S_FETCH);
    case (r_state)
      4'(S_FETCH):  w_next = 4'(S_DECODE);
      4'(S_DECODE): begin
        case (op)
          OP_LW, OP_SW: w_next = 4'(S_MEMADR);
          OP_RTYPE:     w_next = 4'(S_RTYPEEX);
          OP_BEQ:       w_next = 4'(S_BEQEX);
          OP_ADDI:      w_next = 4'(S_ADDIEX);
          OP_J:         w_next = 4'(S_JEX);
          default:      w_next = 4'(S_FETCH);
        endcase
      end
      4'(S_MEMADR):  w_next = (op == OP_SW) ? 4'(S_MEMWR) : 4'(S_MEMRD);
      4'(S_MEMRD):   w_next = 4'(S_MEMWB);
      4'(S_RTYPEEX): w_next = 4'(S_RTYPEWB);
      4'(S_ADDIEX):  w_next = 4'(S_ADDIWB);
      default:       w_next = 4'(S_FETCH);
    endcase
  end

  // Moore output decode from the (reset-qualified) current state.
  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALU;
    w_aluop    = ALUOP_ADD;
    case (w_cur)
      4'(S_FETCH):   begin w_irwrite = 1'b1; w_pcwrite = 1'b1; alusrcb = SRCB_FOUR; end
      4'(S_DECODE):  alusrcb = SRCB_IMMSH;
      4'(S_MEMADR):  begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
      4'(S_MEMRD):   iord = 1'b1;
      4'(S_MEMWB):   begin w_regwrite = 1'b1; memtoreg = 1'b1; end
      4'(S_MEMWR):   begin iord = 1'b1; w_memwrite = 1'b1; end
      4'(S_RTYPEEX): begin alusrca = 1'b1; w_aluop = ALUOP_FUNCT; end
      4'(S_RTYPEWB): begin w_regwrite = 1'b1; regdst = 1'b1; end
      4'(S_BEQEX):   begin alusrca = 1'b1; w_branch = 1'b1; pcsrc = PCSRC_ALUOUT; w_aluop = ALUOP_SUB; end
      4'(S_ADDIEX):  begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
      4'(S_ADDIWB):  w_regwrite = 1'b1;
      4'(S_JEX):     begin w_pcwrite = 1'b1; pcsrc = PCSRC_JUMP; end
      default:       ;
    endcase
  end

  // Strobes are suppressed for the whole reset cycle; selects are left alone.
  assign pcen     = ~reset & (w_pcwrite | (w_branch & zero));
  assign memwrite = ~reset & w_memwrite;
  assign irwrite  = ~reset & w_irwrite;
  assign regwrite = ~reset & w_regwrite;

  alu_decoder u_alu_decoder (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed reset sequences, a table of instruction
// vectors, and randomized instruction streams against an instruction-level model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef struct {
    int st; bit pcen, memwrite, irwrite, regwrite;
    bit iord, memtoreg, regdst, alusrca; int alusrcb, pcsrc;
    int alu; bit alu_valid;
  } exp_t;

  function automatic int cpi(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return 2;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = fetch) of an instruction.
  function automatic exp_t model(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input int k);
    exp_t e = '{default: 0};
    if (k == 0) begin
      e.st = 0; e.irwrite = 1; e.pcen = 1; e.alusrcb = 1; e.alu = 2; e.alu_valid = 1;
    end else if (k == 1) begin
      e.st = 1; e.alusrcb = 3; e.alu = 2; e.alu_valid = 1;
    end else begin
      case (o)
        6'b100011, 6'b101011: begin
          if (k == 2) begin e.st = 2; e.alusrca = 1; e.alusrcb = 2; e.alu = 2; e.alu_valid = 1; end
          else if (o == 6'b101011) begin e.st = 5; e.iord = 1; e.memwrite = 1; end
          else if (k == 3) begin e.st = 3; e.iord = 1; end
          else begin e.st = 4; e.regwrite = 1; e.memtoreg = 1; end
        end
        6'b000000: begin
          if (k == 2) begin e.st = 6; e.alusrca = 1; e.alu = funct_alu(f); e.alu_valid = 1; end
          else begin e.st = 7; e.regwrite = 1; e.regdst = 1; end
        end
        6'b001000: begin
          if (k == 2) begin e.st = 9; e.alusrca = 1; e.alusrcb = 2; e.alu = 2; e.alu_valid = 1; end
          else e.st = 10;
          if (k == 3) e.regwrite = 1;
        end
        6'b000100: begin
          e.st = 8; e.alusrca = 1; e.pcsrc = 1; e.pcen = z; e.alu = 6; e.alu_valid = 1;
        end
        default: begin e.st = 11; e.pcen = 1; e.pcsrc = 2; end
      endcase
    end
    return e;
  endfunction

  // Run one instruction from FETCH, comparing every cycle to the model.
  task automatic run_model(input logic [5:0] o, input logic [5:0] f);
    exp_t e;
    op = o; funct = f;
    for (int k = 0; k < cpi(o); k++) begin
      zero = 1'($urandom);
      #1;
      e = model(o, f, zero, k);
      chk("rnd_state", state, e.st);
      chk("rnd_strobes", {pcen, memwrite, irwrite, regwrite},
          {e.pcen, e.memwrite, e.irwrite, e.regwrite});
      chk("rnd_selects", {iord, memtoreg, regdst, alusrca, alusrcb, pcsrc},
          {e.iord, e.memtoreg, e.regdst, e.alusrca, 2'(e.alusrcb), 2'(e.pcsrc)});
      if (e.alu_valid) chk("rnd_alu", alucontrol, e.alu);
      @(posedge clk); #1;
    end
    chk("rnd_back_to_fetch", state, 0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    string name; logic [5:0] op; logic [5:0] funct; logic zero;
    int cycles; int regwr; int memwr; int irw; int pcen_ex; int alu_ex;
  } vec_t;

  vec_t vecs[$];

  // Run one instruction observing the DUT until it returns to FETCH.
  task automatic run_vec(input vec_t v);
    int k = 0, nrw = 0, nmw = 0, nir = 0, pc_ex = -1, alu_ex = -1;
    op = v.op; funct = v.funct; zero = v.zero;
    #1;
    chk({v.name, "_start"}, state, 0);
    do begin
      nrw += int'(regwrite); nmw += int'(memwrite); nir += int'(irwrite);
      if (k == 2) begin pc_ex = int'(pcen); alu_ex = int'(alucontrol); end
      @(posedge clk); #1;
      k++;
    end while (state != 0 && k < 12);
    if (v.cycles < 3) pc_ex = -1;
    if (v.alu_ex < 0) alu_ex = -1;
    chk({v.name, "_cycles"}, k, v.cycles);
    chk({v.name, "_regwrite_cnt"}, nrw, v.regwr);
    chk({v.name, "_memwrite_cnt"}, nmw, v.memwr);
    chk({v.name, "_irwrite_cnt"}, nir, v.irw);
    chk({v.name, "_pcen_exec"}, pc_ex, v.pcen_ex);
    chk({v.name, "_alu_exec"}, alu_ex, v.alu_ex);
  endtask

  logic [5:0] ops[7];
  logic [5:0] fns[6];

  initial begin
    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;

    vecs.push_back('{"lw",       6'b100011, 6'b000000, 1'b0, 5, 1, 0, 1,  0,  2});
    vecs.push_back('{"sw",       6'b101011, 6'b000000, 1'b0, 4, 0, 1, 1,  0,  2});
    vecs.push_back('{"r_sub",    6'b000000, 6'b100010, 1'b0, 4, 1, 0, 1,  0,  6});
    vecs.push_back('{"r_slt",    6'b000000, 6'b101010, 1'b1, 4, 1, 0, 1,  0,  7});
    vecs.push_back('{"r_and",    6'b000000, 6'b100100, 1'b0, 4, 1, 0, 1,  0,  0});
    vecs.push_back('{"r_or",     6'b000000, 6'b100101, 1'b0, 4, 1, 0, 1,  0,  1});
    vecs.push_back('{"r_badfn",  6'b000000, 6'b000111, 1'b0, 4, 1, 0, 1,  0,  2});
    vecs.push_back('{"beq_tk",   6'b000100, 6'b000000, 1'b1, 3, 0, 0, 1,  1,  6});
    vecs.push_back('{"beq_nt",   6'b000100, 6'b000000, 1'b0, 3, 0, 0, 1,  0,  6});
    vecs.push_back('{"addi",     6'b001000, 6'b000000, 1'b1, 4, 1, 0, 1,  0,  2});
    vecs.push_back('{"j",        6'b000010, 6'b000000, 1'b0, 3, 0, 0, 1,  1, -1});
    vecs.push_back('{"undef",    6'b111111, 6'b000000, 1'b1, 2, 0, 0, 1, -1, -1});

    // Reset held three cycles with lw on op.
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_state", state, 0);
      chk("rst_strobes", {pcen, memwrite, irwrite, regwrite}, 0);
      chk("rst_alusrcb", alusrcb, 1);
    end
    reset = 1'b0; #1;
    chk("first_irwrite", irwrite, 1);
    chk("first_pcen", pcen, 1);
    chk("first_alusrcb", alusrcb, 1);
    chk("first_state", state, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Randomized instruction stream against the model.
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(6)];
      if ($urandom_range(5) == 0) o = 6'($urandom);
      f = fns[$urandom_range(5)];
      if ($urandom_range(4) == 0) f = 6'($urandom);
      run_model(o, f);
    end

    // Reset during MEMRD of a lw: no writeback pulse follows.
    op = 6'b100011; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_in_memrd", state, 3);
    reset = 1'b1; #1;
    chk("midrst_state_during", state, 0);
    chk("midrst_strobes_during", {pcen, memwrite, irwrite, regwrite}, 0);
    @(posedge clk); #1;
    chk("midrst_state_after", state, 0);
    reset = 1'b0; #1;
    chk("midrst_regwrite_fetch", regwrite, 0);
    chk("midrst_irwrite_fetch", irwrite, 1);
    @(posedge clk); #1;
    chk("midrst_decode", state, 1);
    chk("midrst_regwrite_decode", regwrite, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
